m3_block_scheduler: RTL and testbench
=====================================

// Module: m3_block_scheduler
// PURPOSE
// Frame-level scheduler between the lossless bitstream decoder and the IDCT stage (milestone 2).
// Sequences all Y/U/V 8x8 blocks of one frame through a two-buffer (ping-pong) coefficient RAM:
// - the decoder fills block n into one buffer;
// - meanwhile the IDCT consumes block n-1 from the other buffer.
// Also supplies the IDCT with the block position and segment of the block it processes.
// PARAMETERS
// Y_COLS     40  8x8 block columns in the Y segment
// UV_COLS    20  8x8 block columns in each of the U and V segments
// ROWS       30  8x8 block rows per segment
// DONE_MASK  2   cycles after a dec_ena pulse during which dec_done is ignored (stale level)
// PORTS
// CLOCK_50_I   in   1  50 MHz clock
// resetn       in   1  asynchronous, active-low reset
// start        in   1  single-cycle pulse; begins one frame (ignored while busy)
// dec_ena      out  1  single-cycle pulse; decoder decodes the next block into dec_buf_sel
// dec_done     in   1  decoder level flag; high = block fully written, held until the next dec_ena
// idct_start   out  1  single-cycle pulse; IDCT processes the block in idct_buf_sel
// idct_done    in   1  single-cycle pulse; IDCT finished, including its SRAM writes
// dec_buf_sel  out  1  coefficient buffer the decoder writes
// idct_buf_sel out  1  coefficient buffer the IDCT reads; always equals ~dec_buf_sel
// blk_col      out  6  block column of the block now given to the IDCT
// blk_row      out  5  block row of the block now given to the IDCT
// seg          out  2  segment of the IDCT block: 0=Y, 1=U, 2=V (3 is never driven)
// busy         out  1  high from the cycle after an accepted start until frame_done
// frame_done   out  1  single-cycle pulse when the last IDCT of the frame completes
// BEHAVIOUR
// Reset values: every output 0; internal state S_IDLE; all counters 0; both done flags 0.
// Block order:
// - segment Y, then U, then V; row-major within each segment;
// - NBLK = ROWS*(Y_COLS+2*UV_COLS).
// States:
// - S_IDLE:  on start -> S_PRIME, busy<=1, dec_buf_sel<=0, decode index d<=0, IDCT index i<=0.
// - S_PRIME: decode block 0 only. dec_ena pulses the cycle after entry.
//   When the decode completes: toggle dec_buf_sel, d<=1, -> S_RUN.
// - S_RUN:   the cycle after entry, dec_ena (block d) and idct_start (block i) pulse together.
//   The phase ends when both the decode and the IDCT are complete, in either order or the same cycle.
//   At phase end: toggle dec_buf_sel, d<=d+1, i<=i+1.
//   Then -> S_RUN if d+1<NBLK, else -> S_DRAIN.
// - S_DRAIN: idct_start (block NBLK-1) pulses the cycle after entry.
//   On idct_done -> S_DONE.
// - S_DONE:  frame_done=1 and busy<=0 for one cycle -> S_IDLE.
// Decode completion:
// - a mask counter loads DONE_MASK on each dec_ena;
// - dec_done counts as complete only when the mask counter is 0.
// IDCT completion:
// - idct_done sets a sticky flag; the flag clears at phase end;
// - idct_done arriving while no IDCT is outstanding is ignored.
// Position outputs:
// - blk_col/blk_row/seg are registered and update on the same edge that raises idct_start;
// - they are held stable until the next idct_start.
// Position counter (IDCT index):
// - col wraps at Y_COLS-1 (Y) or UV_COLS-1 (U/V), then row increments;
// - row wraps at ROWS-1, then seg increments; no arithmetic overflow is possible.
// A start during busy is dropped. A reset mid-frame aborts immediately to S_IDLE with outputs at reset values.
// Latency: start -> first dec_ena = 2 cycles. idct_done of the last block -> frame_done = 1 cycle.
// TESTING
// Bench parameters: Y_COLS=2, UV_COLS=1, ROWS=1, so NBLK=4.
// Each scenario ends with a check that no dec_ena or idct_start appears after frame_done.
// 1. One start; decoder done after 5 cycles, IDCT done after 10 cycles, per request.
//    -> 4 dec_ena and 4 idct_start pulses; (seg,col,row) = (0,0,0),(0,1,0),(1,0,0),(2,0,0);
//    -> exactly one frame_done pulse.
// 2. Decoder slower than the IDCT (30 vs 4 cycles).
//    -> each phase ends on the dec_done edge; buffer selects toggle exactly 4 times; idct_buf_sel==~dec_buf_sel always.
// 3. dec_done held high from the previous block; new dec_ena issued.
//    -> no advance during the DONE_MASK cycles; phase ends only when the IDCT is also complete.
// 4. idct_done and a valid dec_done in the same cycle -> the next pulses fire exactly 2 cycles later.
// 5. Spurious idct_done in S_IDLE, plus start pulsed again mid-frame.
//    -> no state change; the frame still completes with 4 blocks.
// 6. resetn low during the second S_RUN phase.
//    -> all outputs 0 immediately; a following start runs a full 4-block frame from (0,0,0).

Source files
------------

// File: rtl/m3_block_scheduler_if.sv
// Handshake bundle between the block scheduler, the lossless decoder and the IDCT stage.
// Signals:
//   start        frame start pulse (from the frame controller)
//   dec_ena      decode-next-block pulse (scheduler -> decoder)
//   dec_done     decoder level flag, held until the next dec_ena (decoder -> scheduler)
//   idct_start   IDCT-next-block pulse (scheduler -> IDCT)
//   idct_done    IDCT finished pulse (IDCT -> scheduler)
//   dec_buf_sel  coefficient buffer the decoder writes
//   idct_buf_sel coefficient buffer the IDCT reads
//   blk_col/blk_row/seg  position of the block handed to the IDCT
//   busy         frame in progress
//   frame_done   last IDCT of the frame finished
// The master modport is the scheduler's view; slave is the view of its surroundings.
interface m3_block_scheduler_if;
  logic       start;
  logic       dec_ena;
  logic       dec_done;
  logic       idct_start;
  logic       idct_done;
  logic       dec_buf_sel;
  logic       idct_buf_sel;
  logic [5:0] blk_col;
  logic [4:0] blk_row;
  logic [1:0] seg;
  logic       busy;
  logic       frame_done;

  modport master (
    input  start, dec_done, idct_done,
    output dec_ena, idct_start, dec_buf_sel, idct_buf_sel,
           blk_col, blk_row, seg, busy, frame_done
  );

  modport slave (
    output start, dec_done, idct_done,
    input  dec_ena, idct_start, dec_buf_sel, idct_buf_sel,
           blk_col, blk_row, seg, busy, frame_done
  );
endinterface

// File: rtl/m3_block_scheduler.sv
// Frame-level scheduler between the lossless decoder and the IDCT stage.
// Walks every Y, U and V 8x8 block of a frame through a ping-pong coefficient
// RAM: the decoder fills block n into one buffer while the IDCT consumes
// block n-1 from the other. Also tells the IDCT which block it is processing.
// Ports:
//   CLOCK_50_I  50 MHz clock
//   resetn      asynchronous, active-low reset
//   bus         m3_block_scheduler_if.master (handshakes, buffer selects,
//               block position, busy, frame_done)
module m3_block_scheduler #(
  parameter int Y_COLS    = 40,
  parameter int UV_COLS   = 20,
  parameter int ROWS      = 30,
  parameter int DONE_MASK = 2
) (
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  m3_block_scheduler_if.master   bus
);

  localparam int NBLK = ROWS * (Y_COLS + 2 * UV_COLS);
  localparam int DW   = $clog2(NBLK + 1);
  localparam int MW   = $clog2(DONE_MASK + 2);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic          launch;
  logic [DW-1:0] d_cnt;
  logic [5:0]    col_cnt;
  logic [4:0]    row_cnt;
  logic [1:0]    seg_cnt;
  logic [MW-1:0] mask_cnt;
  logic          dec_flag;
  logic          idct_flag;

  logic          dec_hit;
  logic          idct_hit;
  logic          dec_cmp;
  logic          idct_cmp;
  logic [5:0]    last_col;

  // dec_done is a level that still shows the previous block while a new
  // decode starts, so it only counts once the request is out (launch low),
  // the dec_ena cycle itself is over and the mask window has run down.
  // idct_done only counts while an IDCT is actually outstanding.
  always_comb begin
    dec_hit  = 1'b0;
    idct_hit = 1'b0;
    if ((state == S_PRIME || state == S_RUN) && !launch && !bus.dec_ena &&
        !dec_flag && mask_cnt == '0 && bus.dec_done)
      dec_hit = 1'b1;
    if ((state == S_RUN || state == S_DRAIN) && !launch && !idct_flag && bus.idct_done)
      idct_hit = 1'b1;
    dec_cmp  = dec_flag | dec_hit;
    idct_cmp = idct_flag | idct_hit;
    last_col = (seg_cnt == 2'd0) ? 6'(Y_COLS - 1) : 6'(UV_COLS - 1);
  end

  // launch marks the first cycle of a phase: the request pulses are issued
  // from it so they appear one cycle after the state is entered.
  // idct_buf_sel is a register rather than ~dec_buf_sel so that both read 0
  // out of reset; from the first accepted start they are complementary.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state            <= S_IDLE;
      launch           <= 1'b0;
      d_cnt            <= '0;
      col_cnt          <= '0;
      row_cnt          <= '0;
      seg_cnt          <= '0;
      mask_cnt         <= '0;
      dec_flag         <= 1'b0;
      idct_flag        <= 1'b0;
      bus.dec_ena      <= 1'b0;
      bus.idct_start   <= 1'b0;
      bus.dec_buf_sel  <= 1'b0;
      bus.idct_buf_sel <= 1'b0;
      bus.blk_col      <= '0;
      bus.blk_row      <= '0;
      bus.seg          <= '0;
      bus.busy         <= 1'b0;
      bus.frame_done   <= 1'b0;
    end else begin
      bus.dec_ena    <= 1'b0;
      bus.idct_start <= 1'b0;
      bus.frame_done <= 1'b0;

      if (bus.dec_ena)
        mask_cnt <= MW'(DONE_MASK);
      else if (mask_cnt != '0)
        mask_cnt <= mask_cnt - 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state            <= S_PRIME;
            launch           <= 1'b1;
            bus.busy         <= 1'b1;
            bus.dec_buf_sel  <= 1'b0;
            bus.idct_buf_sel <= 1'b1;
            d_cnt            <= '0;
            col_cnt          <= '0;
            row_cnt          <= '0;
            seg_cnt          <= '0;
            dec_flag         <= 1'b0;
            idct_flag        <= 1'b0;
          end
        end

        S_PRIME: begin
          if (launch) begin
            launch      <= 1'b0;
            bus.dec_ena <= 1'b1;
          end else if (dec_hit) begin
            bus.dec_buf_sel  <= ~bus.dec_buf_sel;
            bus.idct_buf_sel <= ~bus.idct_buf_sel;
            d_cnt            <= DW'(1);
            launch           <= 1'b1;
            state            <= S_RUN;
          end
        end

        S_RUN: begin
          if (launch) begin
            launch         <= 1'b0;
            bus.dec_ena    <= 1'b1;
            bus.idct_start <= 1'b1;
            bus.blk_col    <= col_cnt;
            bus.blk_row    <= row_cnt;
            bus.seg        <= seg_cnt;
          end else if (dec_cmp && idct_cmp) begin
            bus.dec_buf_sel  <= ~bus.dec_buf_sel;
            bus.idct_buf_sel <= ~bus.idct_buf_sel;
            d_cnt            <= d_cnt + 1'b1;
            dec_flag         <= 1'b0;
            idct_flag        <= 1'b0;
            launch           <= 1'b1;
            // Step the IDCT block position: column, then row, then segment.
            if (col_cnt == last_col) begin
              col_cnt <= '0;
              if (row_cnt == 5'(ROWS - 1)) begin
                row_cnt <= '0;
                seg_cnt <= seg_cnt + 1'b1;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
            state <= (int'(d_cnt) + 1 < NBLK) ? S_RUN : S_DRAIN;
          end else begin
            if (dec_hit)  dec_flag  <= 1'b1;
            if (idct_hit) idct_flag <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (launch) begin
            launch         <= 1'b0;
            bus.idct_start <= 1'b1;
            bus.blk_col    <= col_cnt;
            bus.blk_row    <= row_cnt;
            bus.seg        <= seg_cnt;
          end else if (idct_hit) begin
            bus.frame_done <= 1'b1;
            state          <= S_DONE;
          end
        end

        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m3_block_scheduler.sv
// Self-checking bench for m3_block_scheduler with a 4-block frame
// (Y_COLS=2, UV_COLS=1, ROWS=1). Decoder and IDCT behavioural models answer
// the request pulses; a scoreboard holds the expected block positions.
module tb_m3_block_scheduler;

  localparam int DONE_MASK = 2;

  typedef struct {
    int dec_lat;
    int idct_lat;
    int stale;
    int exp_blocks;
    int exp_toggles;
  } vec_t;

  typedef struct {
    int seg;
    int col;
    int row;
    int bsel;
  } pos_t;

  logic CLOCK_50_I;
  logic resetn;

  m3_block_scheduler_if bus ();

  m3_block_scheduler #(
    .Y_COLS(2), .UV_COLS(1), .ROWS(1), .DONE_MASK(DONE_MASK)
  ) dut (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn(resetn),
    .bus(bus)
  );

  initial begin
    CLOCK_50_I = 1'b0;
    forever #10 CLOCK_50_I = ~CLOCK_50_I;
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   dec_lat = 5, idct_lat = 10, stale_hold = 0;
  bit   spur_req = 0;
  bit   dec_out = 0, idct_out = 0;
  int   ena_cyc = 0, idct_cyc = 0;
  int   exp_next = -1, exp_fd = -1;
  int   n_dec = 0, n_idct = 0, n_fd = 0;
  int   toggles = 0, inv_err = 0, stray = 0, dec_blk = 0;
  bit   after_fd = 0;
  logic prev_sel = 1'b0;

  pos_t sb[$];
  pos_t exp_pos[4];
  vec_t vecs[4];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int packedOutputs();
    return int'({bus.dec_ena, bus.idct_start, bus.dec_buf_sel, bus.idct_buf_sel,
                 bus.blk_col, bus.blk_row, bus.seg, bus.busy, bus.frame_done});
  endfunction

  // Per-cycle monitor plus decoder and IDCT models, sampled 1 ns after the edge.
  initial begin
    bus.dec_done  = 1'b0;
    bus.idct_done = 1'b0;
    forever begin
      int age;
      pos_t e;
      @(posedge CLOCK_50_I);
      #1;
      cyc++;
      if (!resetn) begin
        bus.dec_done  = 1'b0;
        bus.idct_done = 1'b0;
        dec_out  = 0;
        idct_out = 0;
        spur_req = 0;
        continue;
      end

      if (bus.busy && (bus.idct_buf_sel !== ~bus.dec_buf_sel)) inv_err++;
      if (bus.dec_buf_sel !== prev_sel) toggles++;
      prev_sel = bus.dec_buf_sel;

      if (bus.dec_ena) begin
        n_dec++;
        if (after_fd) stray++;
        checkOutput("dec_ena_cycle", cyc, exp_next);
        checkOutput("dec_buf_sel", int'(bus.dec_buf_sel), dec_blk % 2);
        dec_blk++;
        ena_cyc = cyc;
        dec_out = 1;
      end

      if (bus.idct_start) begin
        n_idct++;
        if (after_fd) stray++;
        checkOutput("idct_start_cycle", cyc, exp_next);
        if (sb.size() == 0) begin
          checkOutput("scoreboard_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("seg", int'(bus.seg), e.seg);
          checkOutput("blk_col", int'(bus.blk_col), e.col);
          checkOutput("blk_row", int'(bus.blk_row), e.row);
          checkOutput("idct_buf_sel", int'(bus.idct_buf_sel), e.bsel);
        end
        idct_cyc = cyc;
        idct_out = 1;
      end

      if (bus.frame_done) begin
        n_fd++;
        after_fd = 1;
        checkOutput("frame_done_cycle", cyc, exp_fd);
      end

      // Decoder: keeps the old level for stale_hold cycles, low until
      // dec_lat, then high and held. It only counts after the mask window.
      if (dec_out) begin
        age = cyc - ena_cyc;
        if (age >= dec_lat)
          bus.dec_done = 1'b1;
        else if (age > stale_hold)
          bus.dec_done = 1'b0;
        if (bus.dec_done && age >= DONE_MASK + 1) begin
          dec_out = 0;
          if (!idct_out) begin
            exp_next = cyc + 2;
            exp_fd   = cyc + 1;
          end
        end
      end

      bus.idct_done = 1'b0;
      if (spur_req) begin
        bus.idct_done = 1'b1;
        spur_req = 0;
      end
      if (idct_out && (cyc - idct_cyc == idct_lat)) begin
        bus.idct_done = 1'b1;
        idct_out = 0;
        if (!dec_out) begin
          exp_next = cyc + 2;
          exp_fd   = cyc + 1;
        end
      end
    end
  end

  task automatic startFrame(input vec_t v);
    @(posedge CLOCK_50_I);
    #2;
    dec_lat    = v.dec_lat;
    idct_lat   = v.idct_lat;
    stale_hold = v.stale;
    n_dec = 0; n_idct = 0; n_fd = 0;
    toggles = 0; inv_err = 0; stray = 0; dec_blk = 0;
    after_fd = 0;
    prev_sel = bus.dec_buf_sel;
    exp_fd   = -1;
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back(exp_pos[i]);
    exp_next  = cyc + 2;
    bus.start = 1'b1;
  endtask

  task automatic waitFrame(input bit disturb);
    int k;
    k = 0;
    while (n_fd == 0 && k < 2000) begin
      @(posedge CLOCK_50_I);
      #2;
      k++;
      if (disturb && k == 3) spur_req = 1;
      bus.start = (disturb && k == 20) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    if (n_fd == 0) checkOutput("frame_timeout", 0, 1);
    repeat (20) @(posedge CLOCK_50_I);
    #2;
  endtask

  task automatic checkFrame(input vec_t v);
    checkOutput("dec_ena_count", n_dec, v.exp_blocks);
    checkOutput("idct_start_count", n_idct, v.exp_blocks);
    checkOutput("frame_done_count", n_fd, 1);
    checkOutput("buf_toggles", toggles, v.exp_toggles);
    checkOutput("buf_sel_complement", inv_err, 0);
    checkOutput("pulses_after_frame_done", stray, 0);
    checkOutput("scoreboard_left", sb.size(), 0);
    checkOutput("busy_after_frame", int'(bus.busy), 0);
  endtask

  task automatic applyStimulus(input vec_t v, input bit disturb);
    startFrame(v);
    waitFrame(disturb);
    checkFrame(v);
  endtask

  initial begin
    int k;
    resetn        = 1'b0;
    bus.start     = 1'b0;
    exp_pos[0] = '{seg: 0, col: 0, row: 0, bsel: 0};
    exp_pos[1] = '{seg: 0, col: 1, row: 0, bsel: 1};
    exp_pos[2] = '{seg: 1, col: 0, row: 0, bsel: 0};
    exp_pos[3] = '{seg: 2, col: 0, row: 0, bsel: 1};
    vecs[0] = '{dec_lat: 5,  idct_lat: 10, stale: 0, exp_blocks: 4, exp_toggles: 4};
    vecs[1] = '{dec_lat: 30, idct_lat: 4,  stale: 0, exp_blocks: 4, exp_toggles: 4};
    vecs[2] = '{dec_lat: 3,  idct_lat: 1,  stale: 2, exp_blocks: 4, exp_toggles: 4};
    vecs[3] = '{dec_lat: 6,  idct_lat: 6,  stale: 1, exp_blocks: 4, exp_toggles: 4};

    repeat (3) @(posedge CLOCK_50_I);
    #2;
    checkOutput("reset_outputs", packedOutputs(), 0);
    resetn = 1'b1;
    repeat (2) @(posedge CLOCK_50_I);
    #2;
    checkOutput("idle_outputs", packedOutputs(), 0);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d: dec_lat=%0d idct_lat=%0d stale=%0d",
               i, vecs[i].dec_lat, vecs[i].idct_lat, vecs[i].stale);
      applyStimulus(vecs[i], 1'b0);
    end

    // Spurious idct_done while idle, then a frame disturbed by a spurious
    // idct_done during priming and a second start mid-frame.
    $display("[TB] spurious idct_done and repeated start");
    n_dec = 0; n_idct = 0; n_fd = 0;
    spur_req = 1;
    repeat (6) @(posedge CLOCK_50_I);
    #2;
    checkOutput("idle_spur_busy", int'(bus.busy), 0);
    checkOutput("idle_spur_pulses", n_dec + n_idct + n_fd, 0);
    applyStimulus(vecs[0], 1'b1);

    // Reset in the middle of the second RUN phase, then a clean frame.
    $display("[TB] reset mid-frame");
    startFrame(vecs[0]);
    k = 0;
    while (n_dec < 3 && k < 500) begin
      @(posedge CLOCK_50_I);
      #2;
      bus.start = 1'b0;
      k++;
    end
    checkOutput("reach_second_run", n_dec, 3);
    repeat (2) @(posedge CLOCK_50_I);
    #5;
    resetn = 1'b0;
    #1;
    checkOutput("abort_outputs", packedOutputs(), 0);
    repeat (2) @(posedge CLOCK_50_I);
    #2;
    checkOutput("abort_outputs_held", packedOutputs(), 0);
    resetn = 1'b1;
    repeat (2) @(posedge CLOCK_50_I);
    applyStimulus(vecs[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
